// File: rtl/regfile_write_decoder_pkg.sv
// Shared types and helpers for the register-file write-enable decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   SEL_W_DEF  default select width
//   MAX_N      widest one-hot vector any legal configuration produces (SEL_W=6)
//   state_t    sweep FSM states
//   onehot()   width-bit vector with bit idx set, returned in a MAX_N container
package regfile_pkg;

    localparam int SEL_W_DEF = 4;
    localparam int MAX_N     = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // Bits at or above 'width' stay clear so callers can truncate to their
    // own row count without picking up a stray bit.
    function automatic logic [MAX_N-1:0] onehot(input int idx, input int width);
        logic [MAX_N-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if ((i < width) && (i == idx)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/regfile_write_decoder_if.sv
// Bundle between write-address decode and the register-file row enables.
// Latency: n/a (wiring only).
// Backpressure: none; the request side is fire-and-forget, drops are reported on wr_drop.
//
// master: drives wr_en, wr_sel, clr_req; observes row_en, clr_busy, clr_done, wr_drop
// slave : the decoder itself
interface regfile_write_decoder_if
    import regfile_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF
);
    localparam int N_OUT = 2 ** SEL_W;

    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic             clr_req;
    logic [N_OUT-1:0] row_en;
    logic             clr_busy;
    logic             clr_done;
    logic             wr_drop;

    modport master (
        output wr_en,
        output wr_sel,
        output clr_req,
        input  row_en,
        input  clr_busy,
        input  clr_done,
        input  wr_drop
    );

    modport slave (
        input  wr_en,
        input  wr_sel,
        input  clr_req,
        output row_en,
        output clr_busy,
        output clr_done,
        output wr_drop
    );

endinterface

// File: rtl/regfile_write_decoder_onehot_dec.sv
// Combinational binary-to-one-hot decoder with an enable.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   i_en      decode enable; low forces all outputs to zero
//   i_sel     binary index
//   o_onehot  one bit set for a valid index, all zero otherwise
module onehot_dec #(
    parameter int SEL_W = 4,
    parameter int N_OUT = 2 ** SEL_W
) (
    input  logic             i_en,
    input  logic [SEL_W-1:0] i_sel,
    output logic [N_OUT-1:0] o_onehot
);

    // An equality compare per row rather than a shift: an X/Z select makes
    // every compare false, so the output falls back to all-zero instead of
    // smearing X across the row enables.
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (i_sel == SEL_W'(i)) begin
                    o_onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_write_decoder.sv
// Registered one-hot write-enable decoder with optional hardwired row 0 and a clear sweep.
// Latency: 1 cycle from wr_en/wr_sel or clr_req to row_en.
// Backpressure: none; writes arriving while a sweep is mid-flight are dropped and flagged on wr_drop.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset, wins over every other input
//   bus.wr_en     write request          bus.wr_sel    binary row index
//   bus.clr_req   start a clear sweep    bus.row_en    registered row enables (<= 1 hot)
//   bus.clr_busy  sweep row driven       bus.clr_done  pulse with the last sweep row
//   bus.wr_drop   pulse: a sampled write was discarded
//
// Legal SEL_W range is 1..6.
module regfile_write_decoder
    import regfile_pkg::*;
#(
    parameter int SEL_W     = SEL_W_DEF,
    parameter bit MASK_ZERO = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_decoder_if.slave bus
);

    localparam int               N_OUT = 2 ** SEL_W;
    // With row 0 hardwired the sweep skips it and is one cycle shorter.
    localparam int               START = MASK_ZERO ? 1 : 0;
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_OUT - 1);

    state_t           r_state;
    logic [SEL_W-1:0] r_cnt;
    logic [N_OUT-1:0] r_row_en;
    logic             r_busy;
    logic             r_done;
    logic             r_drop;

    logic [N_OUT-1:0] w_dec_row;
    logic [N_OUT-1:0] w_wr_row;
    logic [SEL_W-1:0] w_cnt_inc;

    state_t           w_nxt_state;
    logic [SEL_W-1:0] w_nxt_cnt;
    logic [N_OUT-1:0] w_nxt_row;
    logic             w_nxt_done;
    logic             w_nxt_drop;

    onehot_dec #(
        .SEL_W (SEL_W),
        .N_OUT (N_OUT)
    ) u_dec (
        .i_en     (bus.wr_en),
        .i_sel    (bus.wr_sel),
        .o_onehot (w_dec_row)
    );

    // A write to a hardwired row 0 is a silent no-op, not a drop.
    always_comb begin
        w_wr_row = w_dec_row;
        if (MASK_ZERO) begin
            w_wr_row[0] = 1'b0;
        end
    end

    assign w_cnt_inc = r_cnt + SEL_W'(1);

    // The final sweep row is treated exactly like IDLE so a write or a fresh
    // clr_req can follow the sweep with no bubble cycle.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_row   = '0;
        w_nxt_done  = 1'b0;
        w_nxt_drop  = 1'b0;

        if ((r_state == IDLE) || (r_cnt == LAST)) begin
            if (bus.clr_req) begin
                // Clear beats a simultaneous write.
                w_nxt_state = SWEEP;
                w_nxt_cnt   = SEL_W'(START);
                w_nxt_row   = N_OUT'(onehot(START, N_OUT));
                // Single-row sweep: first row is also the last.
                w_nxt_done  = (START == N_OUT - 1);
                w_nxt_drop  = bus.wr_en;
            end else begin
                w_nxt_state = IDLE;
                w_nxt_row   = w_wr_row;
            end
        end else begin
            w_nxt_cnt  = w_cnt_inc;
            w_nxt_row  = N_OUT'(onehot(int'(w_cnt_inc), N_OUT));
            w_nxt_done = (w_cnt_inc == LAST);
            w_nxt_drop = bus.wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_row_en <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_row_en <= w_nxt_row;
            r_busy   <= (w_nxt_state == SWEEP);
            r_done   <= w_nxt_done;
            r_drop   <= w_nxt_drop;
        end
    end

    assign bus.row_en   = r_row_en;
    assign bus.clr_busy = r_busy;
    assign bus.clr_done = r_done;
    assign bus.wr_drop  = r_drop;

endmodule

// File: tb/tb_regfile_write_decoder.sv
module tb_regfile_write_decoder;
    import regfile_pkg::*;

    typedef struct packed {
        logic [15:0] row;
        logic        busy;
        logic        done;
        logic        drop;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;

    int n_pass;
    int n_total;

    exp_t qa[$];
    exp_t qb[$];

    regfile_write_decoder_if #(.SEL_W(4)) if_a ();
    regfile_write_decoder_if #(.SEL_W(3)) if_b ();

    regfile_write_decoder #(.SEL_W(4), .MASK_ZERO(1'b0)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (if_a.slave)
    );

    regfile_write_decoder #(.SEL_W(3), .MASK_ZERO(1'b1)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (if_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input exp_t exp, input exp_t act, input int pop);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got row=%h busy=%b done=%b drop=%b, want row=%h busy=%b done=%b drop=%b",
                     name, $time, act.row, act.busy, act.done, act.drop,
                     exp.row, exp.busy, exp.done, exp.drop);
        end
        n_total++;
        if (pop <= 1) begin
            n_pass++;
        end else begin
            $display("FAIL %s_onehot @%0t: popcount=%0d, want <=1", name, $time, pop);
        end
    endtask

    // Monitors: outputs settle just after the edge that the matching
    // stimulus was sampled on.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("dutA", e, {if_a.row_en, if_a.clr_busy, if_a.clr_done, if_a.wr_drop},
                  $countones(if_a.row_en));
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("dutB", e, {8'h00, if_b.row_en, if_b.clr_busy, if_b.clr_done, if_b.wr_drop},
                  $countones(if_b.row_en));
        end
    end

    // Drive one cycle of stimulus and queue the response expected after the next edge.
    task automatic step_a(input logic rst, input logic wr, input logic [3:0] sel, input logic clr,
                          input logic [15:0] row, input logic busy, input logic done, input logic drop);
        rst_a        = rst;
        if_a.wr_en   = wr;
        if_a.wr_sel  = sel;
        if_a.clr_req = clr;
        qa.push_back({row, busy, done, drop});
        @(negedge clk);
    endtask

    task automatic step_b(input logic rst, input logic wr, input logic [2:0] sel, input logic clr,
                          input logic [7:0] row, input logic busy, input logic done, input logic drop);
        rst_b        = rst;
        if_b.wr_en   = wr;
        if_b.wr_sel  = sel;
        if_b.clr_req = clr;
        qb.push_back({8'h00, row, busy, done, drop});
        @(negedge clk);
    endtask

    task automatic sweep_tail_a(input int from);
        for (int k = from; k < 16; k++) begin
            step_a(1'b0, 1'b0, 4'd0, 1'b0, 16'h0001 << k, 1'b1, (k == 15), 1'b0);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_a = 1'b1;  if_a.wr_en = 1'b0; if_a.wr_sel = '0; if_a.clr_req = 1'b0;
        rst_b = 1'b1;  if_b.wr_en = 1'b0; if_b.wr_sel = '0; if_b.clr_req = 1'b0;

        // ---------------- DUT A: SEL_W=4, MASK_ZERO=0 ----------------
        step_a(1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 1'b1, 4'd7, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);

        // walk every write row
        for (int s = 0; s < 16; s++) begin
            step_a(1'b0, 1'b1, 4'(s), 1'b0, 16'h0001 << s, 1'b0, 1'b0, 1'b0);
        end
        step_a(1'b0, 1'b0, 4'd5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // full sweep
        step_a(1'b0, 1'b0, 4'd0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        sweep_tail_a(1);
        step_a(1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // clear and write on the same edge; write mid-sweep; back-to-back write
        step_a(1'b0, 1'b1, 4'd5, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 16; k++) begin
            step_a(1'b0, (k == 4), 4'd2, 1'b1, 16'h0001 << k, 1'b1, (k == 15), (k == 4));
        end
        step_a(1'b0, 1'b1, 4'd9, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // back-to-back sweeps
        step_a(1'b0, 1'b0, 4'd0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        sweep_tail_a(1);
        step_a(1'b0, 1'b0, 4'd0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        sweep_tail_a(1);
        step_a(1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // reset while row 6 is showing
        step_a(1'b0, 1'b0, 4'd0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 7; k++) begin
            step_a(1'b0, 1'b0, 4'd0, 1'b0, 16'h0001 << k, 1'b1, 1'b0, 1'b0);
        end
        step_a(1'b1, 1'b1, 4'd3, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step_a(1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        end
        step_a(1'b0, 1'b1, 4'd3, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // ---------------- DUT B: SEL_W=3, MASK_ZERO=1 ----------------
        step_b(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step_b(1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step_b(1'b0, 1'b1, 3'd5, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0);
        step_b(1'b0, 1'b1, 3'd1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        step_b(1'b0, 1'b0, 3'd0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        for (int k = 2; k < 8; k++) begin
            step_b(1'b0, 1'b0, 3'd0, 1'b0, 8'h01 << k, 1'b1, (k == 7), 1'b0);
        end
        step_b(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // clear with a simultaneous write to the hardwired row still reports the drop
        step_b(1'b0, 1'b1, 3'd0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
        for (int k = 2; k < 8; k++) begin
            step_b(1'b0, 1'b0, 3'd0, 1'b0, 8'h01 << k, 1'b1, (k == 7), 1'b0);
        end
        step_b(1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step_b(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // drain the scoreboards with a bounded wait
        for (int i = 0; i < 5 && (qa.size() > 0 || qb.size() > 0); i++) begin
            @(negedge clk);
        end
        if (qa.size() > 0 || qb.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d/%0d expectations left unchecked, want 0/0", qa.size(), qb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_write_decoder.md
Name: regfile_write_decoder

Overview:
- Parametrised, registered binary-to-one-hot write-enable decoder for the register file.
- Successor to the fixed 4-to-16 combinational decoder, with configurable select width.
- Adds an optional hardwired-zero row and a sequential clear sweep that asserts every row once, one per cycle, so the register file can be zeroed without per-row logic.
- Sits between the instruction decode write-address field and the register-file row enables.

Parameters:
- SEL_W, 4, select width in bits; legal range 1..6.
- N_OUT, 2**SEL_W, number of one-hot outputs. Derived localparam, not overridable.
- MASK_ZERO, 0, when 1 row 0 is hardwired: never asserted by writes or by the sweep.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request for this cycle.
- wr_sel  input  SEL_W  binary row index for the write.
- clr_req  input  1  request to start a clear sweep.
- row_en  output  N_OUT  registered row enables; at most one bit set.
- clr_busy  output  1  registered; high on every cycle a sweep row is driven.
- clr_done  output  1  registered one-cycle pulse, coincident with the last sweep row.
- wr_drop  output  1  registered one-cycle pulse: a wr_en was sampled but not decoded.

Behaviour:
- Reset: row_en=0, clr_busy=0, clr_done=0, wr_drop=0, state IDLE, index counter cnt=0. Reset wins over all other inputs at that edge.
- START = MASK_ZERO ? 1 : 0; LAST = N_OUT-1. Sweep length = N_OUT-START cycles.
- FSM states: IDLE, SWEEP. clr_busy equals (state==SWEEP).
- IDLE, clr_req=0: row_en <= wr_en ? onehot(wr_sel) : 0. Latency is one cycle.
- MASK_ZERO=1 with wr_sel=0: row_en <= 0 and wr_drop <= 0. This is a legal no-op, not a drop.
- Any select value that is not a valid binary value (X/Z in simulation) drives row_en <= 0.
- IDLE, clr_req=1:
  - state <= SWEEP, cnt <= START, row_en <= onehot(START).
  - A simultaneous wr_en is discarded and wr_drop <= 1 (clear has priority).
- SWEEP, cnt != LAST:
  - cnt <= cnt+1, row_en <= onehot(cnt+1).
  - clr_done <= (cnt+1 == LAST).
  - wr_en is dropped, with wr_drop <= wr_en.
  - clr_req is ignored.
- SWEEP, cnt == LAST: state <= IDLE, and the inputs at this edge are handled exactly as in IDLE. This allows a write or a new clr_req back-to-back with no bubble.
- If the sweep length is 1 (SEL_W=1, MASK_ZERO=1): row_en, clr_busy and clr_done are all set at the edge that samples clr_req.
- clr_done and wr_drop are 0 on every cycle not listed above.
- Reset during SWEEP aborts the sweep: outputs go to reset values and no clr_done is issued.
- Invariant: popcount(row_en) <= 1 on every cycle. Under MASK_ZERO=1, row_en[0] is always 0.

Decomposition:
- Shared package regfile_pkg holds:
  - SEL_W default constant;
  - state enum {IDLE, SWEEP};
  - function onehot(idx, width) returning a width-bit vector with bit idx set.
- One sub-module is natural: onehot_dec, a combinational parametrised binary-to-one-hot decoder with a default-zero branch.
- The FSM, counter and output registers live in regfile_write_decoder itself.

Test Plan:
- Reset then walk writes, SEL_W=4, MASK_ZERO=0: wr_en=1, wr_sel=0..15 on consecutive cycles.
  - Each following cycle row_en = 16'h0001 << sel; wr_drop=0.
  - wr_en=0 gives row_en=0 next cycle.
- Full sweep, SEL_W=4, MASK_ZERO=0: pulse clr_req for 1 cycle.
  - 16 cycles of row_en = 0x0001, 0x0002, ... 0x8000 with clr_busy=1.
  - clr_done=1 only alongside 0x8000, then clr_busy=0.
- Masked zero, SEL_W=3, MASK_ZERO=1:
  - wr_sel=0 with wr_en=1 gives row_en=0 and wr_drop=0.
  - A sweep yields 7 cycles, 8'h02 through 8'h80; row_en[0] is never 1.
- Conflicts: clr_req=1 and wr_en=1 with wr_sel=5 on the same edge.
  - Sweep starts with row_en=0x0001 and wr_drop=1.
  - wr_en=1 mid-sweep gives wr_drop=1 next cycle and the sweep pattern is unchanged.
- Back-to-back: wr_en=1, wr_sel=9 sampled at the edge where row_en=0x8000 in SWEEP.
  - Next cycle row_en=0x0200, clr_busy=0, wr_drop=0.
  - A second clr_req at that same edge instead restarts the sweep at 0x0001.
- Reset mid-sweep: assert reset while row_en=0x0040.
  - Next cycle row_en=0, clr_busy=0, no clr_done pulse.
  - A subsequent write with wr_sel=3 gives 0x0008.
